keypad_col_scanner: RTL and testbench

//  Column-drive half of the hex keypad interface: drives Col[3:0], watches the

---
 rtl/keypad_col_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_col_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_col_scanner.sv
// Column-drive scanner for a 4x4 hex keypad: synchronizes the row lines, walks the
// columns to locate a pressed key, debounces press and release, and reports one Code/Valid per press.
module keypad_col_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Row,
  input  logic       S_Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_meta_p0;
  logic [3:0]       row_s_p1;
  logic [SET_W-1:0] settle_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       pattern;
  logic             settle_last;
  logic             deb_last;
  logic             row_hit;
  logic             pulse_now;

  function automatic logic [SET_W-1:0] settle_inc(input logic [SET_W-1:0] c);
    return (c == SET_W'(SETTLE_CYCLES)) ? c : c + 1'b1;
  endfunction

  function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] c);
    return (c == DEB_W'(DEBOUNCE_CYCLES)) ? c : c + 1'b1;
  endfunction

  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clock) begin
    row_meta_p0 <= Row;
    row_s_p1    <= row_meta_p0;
  end

  assign settle_last = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign deb_last    = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign row_hit     = (row_s_p1 != 4'b0000);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (S_Row) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (settle_last) begin
          if (row_hit)               state_nxt = ST_DEBOUNCE;
          else if (col_idx == 2'd3)  state_nxt = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s_p1 != pattern) state_nxt = ST_IDLE;
        else if (deb_last)       state_nxt = ST_PRESSED;
      end
      ST_PRESSED:  state_nxt = ST_RELEASE;
      ST_RELEASE:  if (!S_Row && deb_last) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // The located column stays driven through debounce so the latched pattern remains comparable
  always_comb begin
    Col       = 4'b1111;
    pulse_now = 1'b0;
    case (state)
      ST_SCAN, ST_DEBOUNCE, ST_PRESSED: Col = 4'b0001 << col_idx;
      default:                          Col = 4'b1111;
    endcase
    if (state == ST_PRESSED) pulse_now = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      settle_cnt <= '0;
      deb_cnt    <= '0;
      col_idx    <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          settle_cnt <= '0;
          deb_cnt    <= '0;
          col_idx    <= 2'd0;
        end
        ST_SCAN: begin
          if (settle_last) begin
            settle_cnt <= '0;
            deb_cnt    <= '0;
            if (!row_hit && col_idx != 2'd3) col_idx <= col_idx + 2'd1;
          end else begin
            settle_cnt <= settle_inc(settle_cnt);
          end
        end
        ST_DEBOUNCE: deb_cnt <= deb_last ? '0 : deb_inc(deb_cnt);
        ST_PRESSED:  deb_cnt <= '0;
        ST_RELEASE: begin
          if (S_Row)          deb_cnt <= '0;
          else if (!deb_last) deb_cnt <= deb_inc(deb_cnt);
        end
        default: begin
          settle_cnt <= '0;
          deb_cnt    <= '0;
        end
      endcase
    end
  end

  // Pattern and row index are captured only at the scan hit and consumed later
  always_ff @(posedge clock) begin
    if (state == ST_SCAN && settle_last && row_hit) begin
      pattern <= row_s_p1;
      row_idx <= lowest_row(row_s_p1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Code  <= 4'h0;
      Valid <= 1'b0;
    end else begin
      Valid <= pulse_now;
      if (pulse_now) Code <= {row_idx, col_idx};
    end
  end

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Bench for keypad_col_scanner: keypad matrix model plus timing reference derived from
// press-to-Valid latency and scan-priority rules; directed scenarios followed by random presses.
module tb_keypad_col_scanner;

  localparam int S = 4;
  localparam int D = 16;

  logic       clock;
  logic       reset;
  logic [3:0] Row;
  logic       S_Row;
  logic [3:0] Col;
  logic [3:0] Code;
  logic       Valid;

  keypad_col_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .Row   (Row),
    .S_Row (S_Row),
    .Col   (Col),
    .Code  (Code),
    .Valid (Valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          n = 0;
  int          exp_valid_step = -1;
  logic [3:0]  exp_code = 4'h0;
  logic [3:0]  model_code = 4'h0;
  logic [15:0] keys = 16'h0;
  logic        force_srow = 1'b0;
  logic        hist1 = 1'b0;
  logic        hist2 = 1'b0;

  function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = |(k[4*i +: 4] & c);
    return r;
  endfunction

  function automatic void locate(input logic [15:0] k, output int col, output logic [3:0] code);
    col = -1;
    code = 4'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col < 0 && k[4*r + c]) begin
          col  = c;
          code = 4'(4*r + c);
        end
  endfunction

  function automatic int lat_of(input int col);
    return S + D + 3 + col * S;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at step %0d", tag, got, expv, n);
    end
  endtask

  task automatic step();
    @(negedge clock);
    Row   = rows_of(keys, Col);
    S_Row = hist2 | force_srow;
    hist2 = hist1;
    hist1 = |Row;
    @(posedge clock);
    #1;
    n++;
    if (reset) begin
      model_code     = 4'h0;
      exp_valid_step = -1;
    end
    check("valid", {3'b000, Valid}, {3'b000, (n == exp_valid_step)});
    if (n == exp_valid_step) model_code = exp_code;
    check("code", Code, model_code);
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic press(input logic [15:0] k);
    int col;
    logic [3:0] code;
    locate(k, col, code);
    keys           = k;
    exp_code       = code;
    exp_valid_step = n + 1 + lat_of(col);
  endtask

  initial begin
    int          col;
    int          h;
    logic [3:0]  code;
    logic [15:0] k;
    reset = 1'b1;
    Row   = 4'h0;
    S_Row = 1'b0;

    // Power-on reset
    for (int i = 0; i < 4; i++) begin
      step();
      check("reset_col", Col, 4'b1111);
    end
    reset = 1'b0;
    run(10);

    // Single key row2/col1 held 200 cycles
    press(16'h1 << 9);
    run(200);
    keys = 16'h0;
    run(40);

    // Reset asserted mid-debounce
    press(16'h1 << 0);
    run(10);
    reset = 1'b1;
    keys  = 16'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_col", Col, 4'b1111);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_idle_col", Col, 4'b1111);
    end
    run(40);

    // Bouncing key never debounces
    exp_valid_step = -1;
    for (int i = 0; i < 6; i++) begin
      keys = 16'h1 << 4;
      run(5);
      keys = 16'h0;
      run(5);
    end
    run(40);

    // Press F, release 20, press 0 -> two pulses
    press(16'h1 << 15);
    run(lat_of(3) + 10);
    keys = 16'h0;
    run(20);
    press(16'h1 << 0);
    run(lat_of(0) + 10);
    keys = 16'h0;
    run(40);

    // Press F, release shorter than debounce, press 0 -> only first pulse
    press(16'h1 << 15);
    run(lat_of(3) + 10);
    keys = 16'h0;
    run(8);
    keys = 16'h1 << 0;
    run(60);
    keys = 16'h0;
    run(40);

    // Multi-key: same column lowest row, different columns lowest column
    press((16'h1 << 6) | (16'h1 << 2));
    run(lat_of(2) + 10);
    keys = 16'h0;
    run(40);
    press((16'h1 << 3) | (16'h1 << 12));
    run(lat_of(0) + 10);
    keys = 16'h0;
    run(40);

    // Activity glitch with no key: full four-column scan then idle
    exp_valid_step = -1;
    force_srow = 1'b1;
    step();
    force_srow = 1'b0;
    check("glitch_col0", Col, 4'b0001);
    for (int c = 1; c <= 4; c++) begin
      run(S);
      check("glitch_col", Col, (c < 4) ? (4'b0001 << c) : 4'b1111);
    end
    run(20);
    check("glitch_idle_col", Col, 4'b1111);

    // Random presses: one or two keys, clearly short or clearly long
    for (int e = 0; e < 16; e++) begin
      k = 16'h0;
      k[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) k[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        locate(k, col, code);
        press(k);
        h = lat_of(col) + 5 + int'($urandom_range(0, 19));
      end else begin
        keys           = k;
        exp_valid_step = -1;
        h = 1 + int'($urandom_range(0, S + D - 3));
      end
      run(h);
      keys = 16'h0;
      run(45);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
